// File: rtl/cgra_cfg_pkg.sv
// Shared types and header layout for the CGRA configuration loader.
package cgra_cfg_pkg;

  typedef enum logic [1:0] {S_HDR, S_LO, S_HI, S_EMIT} cfg_state_t;

  localparam int BCAST_BIT   = 8;
  localparam int N_LSB       = 16;
  localparam int N_MSB       = 23;
  localparam int CFG_FRAME_W = 64;

  // Packet header word. The low byte carries {y, x}; only the low
  // 2*COORD_WIDTH bits of it are meaningful.
  typedef struct packed {
    logic [7:0] rsvd_hi;
    logic [7:0] n;
    logic [6:0] rsvd_mid;
    logic       bcast;
    logic [7:0] coord;
  } cfg_hdr_t;

  function automatic logic [7:0] hdr_n(input cfg_hdr_t h);
    return h.n;
  endfunction

  function automatic logic hdr_bcast(input cfg_hdr_t h);
    return h.bcast;
  endfunction

endpackage

// File: rtl/cgra_cfg_decode.sv
// Target decoder: tile coordinates (or broadcast) to a per-tile strobe vector.
module cgra_cfg_decode
  import cgra_cfg_pkg::*;
#(
  parameter int ROWS        = 4,
  parameter int COLS        = 4,
  parameter int COORD_WIDTH = 4,
  parameter int NUM_TILES   = ROWS * COLS
) (
  input  logic [COORD_WIDTH-1:0] i_x,
  input  logic [COORD_WIDTH-1:0] i_y,
  input  logic                   i_bcast,
  output logic [NUM_TILES-1:0]   o_strobe,
  output logic                   o_in_range
);

  // Broadcast lights every tile; a unicast lights bit y*COLS+x only when in range.
  always_comb begin
    o_strobe   = '0;
    o_in_range = (32'(i_x) < 32'(COLS)) && (32'(i_y) < 32'(ROWS));
    if (i_bcast) begin
      o_strobe = '1;
    end else if (o_in_range) begin
      for (int t = 0; t < NUM_TILES; t++) begin
        if (t == int'(i_y) * COLS + int'(i_x)) o_strobe[t] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cgra_config_loader.sv
// Host word stream -> 64-bit config frames with per-tile strobes.
module cgra_config_loader
  import cgra_cfg_pkg::*;
#(
  parameter  int ROWS        = 4,
  parameter  int COLS        = 4,
  parameter  int COORD_WIDTH = 4,
  localparam int NUM_TILES   = ROWS * COLS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [CFG_FRAME_W-1:0] config_frame,
  output logic [NUM_TILES-1:0]   config_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [15:0]            frame_count
);

  cfg_state_t r_state, w_next;
  logic                   r_live;       // low for the cycle following reset
  logic [COORD_WIDTH-1:0] r_x, r_y;
  logic                   r_bcast;
  logic                   r_drop;       // packet target is out of range
  logic [7:0]             r_remaining;
  logic [31:0]            r_lo;
  logic [CFG_FRAME_W-1:0] r_frame;
  logic [NUM_TILES-1:0]   r_cfg_valid;
  logic                   r_done;
  logic                   r_err;
  logic [15:0]            r_frame_count;

  logic                   w_accept;
  logic                   w_hdr_bcast;
  logic [7:0]             w_hdr_n;
  logic [COORD_WIDTH-1:0] w_dec_x, w_dec_y;
  logic                   w_dec_bcast;
  logic [NUM_TILES-1:0]   w_strobe;
  logic                   w_in_range;

  assign w_hdr_bcast = hdr_bcast(in_data);
  assign w_hdr_n     = hdr_n(in_data);
  assign w_accept    = in_valid && in_ready;

  // While idle the decoder looks at the incoming header so range errors are
  // flagged at header accept; otherwise it decodes the latched packet target.
  assign w_dec_x     = (r_state == S_HDR) ? in_data[COORD_WIDTH-1:0] : r_x;
  assign w_dec_y     = (r_state == S_HDR) ? in_data[2*COORD_WIDTH-1:COORD_WIDTH] : r_y;
  assign w_dec_bcast = (r_state == S_HDR) ? w_hdr_bcast : r_bcast;

  cgra_cfg_decode #(
    .ROWS(ROWS), .COLS(COLS), .COORD_WIDTH(COORD_WIDTH), .NUM_TILES(NUM_TILES)
  ) u_decode (
    .i_x       (w_dec_x),
    .i_y       (w_dec_y),
    .i_bcast   (w_dec_bcast),
    .o_strobe  (w_strobe),
    .o_in_range(w_in_range)
  );

  assign config_frame = r_frame;
  assign config_valid = r_cfg_valid;
  assign done         = r_done;
  assign err          = r_err;
  assign frame_count  = r_frame_count;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_HDR;
    else     r_state <= w_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next   = r_state;
    in_ready = r_live && (r_state != S_EMIT);
    busy     = (r_state != S_HDR);
    case (r_state)
      S_HDR:   if (w_accept && (w_hdr_n != 8'd0)) w_next = S_LO;
      S_LO:    if (w_accept) w_next = S_HI;
      S_HI:    if (w_accept) w_next = S_EMIT;
      S_EMIT:  w_next = (r_remaining == 8'd1) ? S_HDR : S_LO;
      default: w_next = S_HDR;
    endcase
  end

  // Header latch, word assembly, strobe/done pulses and the frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_live        <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_bcast       <= 1'b0;
      r_drop        <= 1'b0;
      r_remaining   <= '0;
      r_lo          <= '0;
      r_frame       <= '0;
      r_cfg_valid   <= '0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_live      <= 1'b1;
      r_done      <= 1'b0;
      r_cfg_valid <= '0;
      case (r_state)
        S_HDR: if (w_accept) begin
          r_x         <= in_data[COORD_WIDTH-1:0];
          r_y         <= in_data[2*COORD_WIDTH-1:COORD_WIDTH];
          r_bcast     <= w_hdr_bcast;
          r_remaining <= w_hdr_n;
          r_drop      <= !w_hdr_bcast && !w_in_range;
          if (!w_hdr_bcast && !w_in_range) r_err <= 1'b1;
          if (w_hdr_n == 8'd0) r_done <= 1'b1;
        end
        S_LO: if (w_accept) r_lo <= in_data;
        S_HI: if (w_accept) begin
          // Dropped frames leave the bus untouched and strobe nothing.
          r_cfg_valid <= w_strobe;
          if (!r_drop) r_frame <= {in_data, r_lo};
          if (r_remaining == 8'd1) r_done <= 1'b1;
        end
        S_EMIT: begin
          r_remaining <= r_remaining - 8'd1;
          if (!r_drop) r_frame_count <= r_frame_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cgra_config_loader.sv
// Directed bench for cgra_config_loader with a packet-level reference model.
module tb_cgra_config_loader;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int NT   = ROWS * COLS;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   in_data;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   config_frame;
  logic [NT-1:0] config_valid;
  logic          busy, done, err;
  logic [15:0]   frame_count;

  cgra_config_loader #(.ROWS(ROWS), .COLS(COLS), .COORD_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .config_frame(config_frame),
    .config_valid(config_valid), .busy(busy), .done(done), .err(err),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model (packet/word level) ----------------
  bit            m_on = 0;
  bit            m_live, m_emit, m_done, m_err;
  int            m_need;       // words still owed by the current packet; 0 = header next
  logic [NT-1:0] m_tgt;
  logic [31:0]   m_lo;
  logic [63:0]   m_frame;
  logic [15:0]   m_cnt;
  int            cyc = 0;

  always @(posedge clk) begin
    bit acc;
    int x, y, n;
    cyc++;
    if (rst) begin
      m_on = 1; m_live = 0; m_need = 0; m_emit = 0; m_done = 0; m_err = 0;
      m_tgt = '0; m_lo = '0; m_frame = '0; m_cnt = '0;
    end else if (m_on) begin
      acc = in_valid && m_live && !m_emit;
      if (m_emit && m_tgt != '0) m_cnt = m_cnt + 16'd1;
      m_emit = 0; m_done = 0; m_live = 1;
      if (acc) begin
        if (m_need == 0) begin
          x = int'(in_data[3:0]); y = int'(in_data[7:4]); n = int'(in_data[23:16]);
          m_need = 2 * n;
          if (in_data[8])                m_tgt = '1;
          else if (x < COLS && y < ROWS) m_tgt = NT'(1) << (y * COLS + x);
          else begin m_tgt = '0; m_err = 1; end
          if (n == 0) m_done = 1;
        end else begin
          if (m_need % 2 == 0) m_lo = in_data;
          else begin
            m_emit = 1;
            if (m_tgt != '0) m_frame = {in_data, m_lo};
            m_done = (m_need == 1);
          end
          m_need--;
        end
      end
    end
  end

  // ---------------- per-cycle compare + emit log ----------------
  typedef struct { logic [NT-1:0] m; logic [63:0] f; int c; logic d; } ev_t;
  ev_t evq[$];
  int  done_cnt = 0;

  always @(negedge clk) begin
    if (m_on) begin
      chk("in_ready", 64'(in_ready), 64'(m_live && !m_emit));
      chk("busy", 64'(busy), 64'((m_need != 0) || m_emit));
      chk("config_valid", 64'(config_valid), 64'(m_emit ? m_tgt : '0));
      chk("config_frame", config_frame, m_frame);
      chk("done", 64'(done), 64'(m_done));
      chk("err", 64'(err), 64'(m_err));
      chk("frame_count", 64'(frame_count), 64'(m_cnt));
      if (config_valid != '0) evq.push_back('{config_valid, config_frame, cyc, done});
      if (done) done_cnt++;
    end
  end

  // ---------------- drivers ----------------
  task automatic send(input logic [31:0] w, input bit gaps);
    int k = 0;
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    in_data = w; in_valid = 1'b1;
    while (!in_ready && k < 20) begin @(negedge clk); k++; end
    if (k == 20) chk("send_timeout", 64'(k), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_cfg_valid", 64'(config_valid), 64'd0);
    chk("rst_frame", config_frame, 64'd0);
    chk("rst_count", 64'(frame_count), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(in_ready), 64'd1);

    // Unicast, 2 frames to (2,1), in_valid held high
    evq.delete();
    send(32'h0002_0012, 0); send(32'h1111_1111, 0); send(32'h2222_2222, 0);
    send(32'h3333_3333, 0); send(32'h4444_4444, 0);
    idle(4);
    chk("t1_nemit", 64'(evq.size()), 64'd2);
    if (evq.size() == 2) begin
      chk("t1_mask0", 64'(evq[0].m), 64'h0040);
      chk("t1_frame0", evq[0].f, 64'h2222_2222_1111_1111);
      chk("t1_mask1", 64'(evq[1].m), 64'h0040);
      chk("t1_frame1", evq[1].f, 64'h4444_4444_3333_3333);
      chk("t1_spacing", 64'(evq[1].c - evq[0].c), 64'd3);
      chk("t1_done0", 64'(evq[0].d), 64'd0);
      chk("t1_done1", 64'(evq[1].d), 64'd1);
    end
    chk("t1_count", 64'(frame_count), 64'd2);

    // Broadcast
    evq.delete();
    send(32'h0001_0100, 0); send(32'hDEAD_BEEF, 0); send(32'h0000_0001, 0);
    idle(3);
    chk("t2_nemit", 64'(evq.size()), 64'd1);
    if (evq.size() == 1) begin
      chk("t2_mask", 64'(evq[0].m), 64'hFFFF);
      chk("t2_frame", evq[0].f, 64'h0000_0001_DEAD_BEEF);
      chk("t2_done", 64'(evq[0].d), 64'd1);
    end

    // Out-of-range target, then a good packet to (3,3)
    evq.delete(); d0 = done_cnt;
    send(32'h0001_0005, 0); send(32'hAAAA_AAAA, 0); send(32'hBBBB_BBBB, 0);
    idle(3);
    chk("t3_nemit_bad", 64'(evq.size()), 64'd0);
    chk("t3_err", 64'(err), 64'd1);
    chk("t3_done", 64'(done_cnt - d0), 64'd1);
    chk("t3_count", 64'(frame_count), 64'd3);
    send(32'h0001_0033, 0); send(32'h5555_5555, 0); send(32'h6666_6666, 0);
    idle(3);
    chk("t3_nemit_good", 64'(evq.size()), 64'd1);
    if (evq.size() == 1) begin
      chk("t3_mask", 64'(evq[0].m), 64'h8000);
      chk("t3_frame", evq[0].f, 64'h6666_6666_5555_5555);
    end

    // Same as first packet with random gaps in in_valid
    evq.delete();
    send(32'h0002_0012, 1); send(32'h1111_1111, 1); send(32'h2222_2222, 1);
    send(32'h3333_3333, 1); send(32'h4444_4444, 1);
    idle(4);
    chk("t4_nemit", 64'(evq.size()), 64'd2);
    if (evq.size() == 2) begin
      chk("t4_frame0", evq[0].f, 64'h2222_2222_1111_1111);
      chk("t4_frame1", evq[1].f, 64'h4444_4444_3333_3333);
      chk("t4_mask1", 64'(evq[1].m), 64'h0040);
    end
    chk("t4_count", 64'(frame_count), 64'd6);

    // Reset after the lo word of a packet to (3,2)
    evq.delete();
    send(32'h0001_0023, 0); send(32'h7777_7777, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_in_ready", 64'(in_ready), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_err", 64'(err), 64'd0);
    chk("t5_count", 64'(frame_count), 64'd0);
    chk("t5_frame", config_frame, 64'd0);
    rst = 1'b0;
    send(32'h0001_0000, 0); send(32'h1234_5678, 0); send(32'h9ABC_DEF0, 0);
    idle(3);
    chk("t5_nemit", 64'(evq.size()), 64'd1);
    if (evq.size() == 1) begin
      chk("t5_mask", 64'(evq[0].m), 64'h0001);
      chk("t5_frame_new", evq[0].f, 64'h9ABC_DEF0_1234_5678);
    end
    chk("t5_count_new", 64'(frame_count), 64'd1);

    // n=0 header
    evq.delete(); d0 = done_cnt;
    send(32'h0000_0000, 0);
    idle(2);
    chk("t6_nemit", 64'(evq.size()), 64'd0);
    chk("t6_done", 64'(done_cnt - d0), 64'd1);
    chk("t6_busy", 64'(busy), 64'd0);

    // frame_count wrap from 0xFFFF
    #1;
    force dut.r_frame_count = 16'hFFFF;
    m_cnt = 16'hFFFF;
    @(negedge clk);
    #1;
    release dut.r_frame_count;
    @(negedge clk);
    send(32'h0001_0001, 0); send(32'hCAFE_0000, 0); send(32'h0000_CAFE, 0);
    idle(3);
    chk("t6_wrap", 64'(frame_count), 64'd0);
    chk("t6_nemit_wrap", 64'(evq.size()), 64'd1);
    if (evq.size() == 1) chk("t6_mask", 64'(evq[0].m), 64'h0002);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
